// File: rtl/btn_pkg.sv
// Shared types for the pushbutton input path: debounce FSM states and counter width.
package btn_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous pin inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw pushbutton into a clean level plus press, release and long-press pulses.
// Cycle counting mirrors the LED blink driver so both blocks scale with the same clock.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic [7:0] press_count
);

  import btn_pkg::*;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             w_btnRaw;
  logic             w_btnSync;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hold;
  logic             r_longDone;

  assign w_btnRaw = ACTIVE_LOW ? ~btn_in : btn_in;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(w_btnRaw),
    .o_q(w_btnSync)
  );

  // A bounce back into PRESSED keeps r_hold, so a long press only stretches by the bounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_hold           <= '0;
      r_longDone       <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= '0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_btnSync) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!w_btnSync) begin
            r_state <= IDLE;
          end else if (r_cnt == DEB_LAST) begin
            r_state     <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            r_hold      <= '0;
            r_longDone  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!w_btnSync) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CNT_W'(1);
          end else if (!r_longDone) begin
            if (r_hold == LONG_LAST) begin
              long_press_pulse <= 1'b1;
              r_longDone       <= 1'b1;
            end else begin
              r_hold <= r_hold + CNT_W'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (w_btnSync) begin
            r_state <= PRESSED;
          end else if (r_cnt == DEB_LAST) begin
            r_state       <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed checks of button_debounce against a run-length reference model.
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnIn;
  logic       btnInLow;
  logic       level, pressP, relP, longP;
  logic [7:0] cnt;
  logic       levelLow, pressLow, relLow, longLow;
  logic [7:0] cntLow;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btnIn),
    .btn_level(level),
    .press_pulse(pressP),
    .release_pulse(relP),
    .long_press_pulse(longP),
    .press_count(cnt)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L),
    .ACTIVE_LOW(1'b1)
  ) dutLow (
    .clk(clk),
    .rst(rst),
    .btn_in(btnInLow),
    .btn_level(levelLow),
    .press_pulse(pressLow),
    .release_pulse(relLow),
    .long_press_pulse(longLow),
    .press_count(cntLow)
  );

  // Level flips after D consecutive synchronized samples disagreeing with it; the hold
  // count advances only on edges where the pressed button was high on this and the last sample.
  typedef struct packed {
    logic        s1, s2, level, prev, longDone, press, rel, lng;
    logic [31:0] run, hold;
    logic [7:0]  count;
  } model_t;

  model_t m, mLow;

  function automatic model_t modelStep(model_t s, logic pin, logic r);
    model_t n = s;
    logic samp;
    n.press = 1'b0;
    n.rel   = 1'b0;
    n.lng   = 1'b0;
    if (r) begin
      n = '0;
      return n;
    end
    samp = s.s2;
    n.s2 = s.s1;
    n.s1 = pin;
    if (samp != s.level) begin
      n.run = s.run + 1;
      if (n.run == D) begin
        n.level = samp;
        n.run   = 0;
        if (samp) begin
          n.press    = 1'b1;
          n.count    = s.count + 8'd1;
          n.hold     = 0;
          n.longDone = 1'b0;
        end else begin
          n.rel = 1'b1;
        end
      end
    end else begin
      n.run = 0;
      if (s.level && s.prev && !s.longDone) begin
        n.hold = s.hold + 1;
        if (n.hold == L) begin
          n.lng      = 1'b1;
          n.longDone = 1'b1;
        end
      end
    end
    n.prev = samp;
    return n;
  endfunction

  always @(posedge clk) begin
    m    <= modelStep(m, btnIn, rst);
    mLow <= modelStep(mLow, ~btnInLow, rst);
  end

  logic [11:0] dutVec, modelVec, lowVec, modelLowVec;
  assign dutVec      = {level, pressP, relP, longP, cnt};
  assign modelVec    = {m.level, m.press, m.rel, m.lng, m.count};
  assign lowVec      = {levelLow, pressLow, relLow, longLow, cntLow};
  assign modelLowVec = {mLow.level, mLow.press, mLow.rel, mLow.lng, mLow.count};

  task automatic releaseAndSettle();
    btnIn = 1'b0;
    repeat (2 * D + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    btnIn    = 1'b0;
    btnInLow = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dutVec !== 12'h000 || lowVec !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h/%h expected 000/000", dutVec, lowVec);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dutVec !== 12'h000 || lowVec !== 12'h000) begin
      errors++;
      $display("[TB] FAIL after_reset_idle: got %h/%h expected 000/000", dutVec, lowVec);
    end
  endtask

  task automatic test_clean_press();
    btnIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dutVec !== modelVec || pressP !== (i == 5) || level !== (i >= 5) ||
          relP !== 1'b0 || longP !== 1'b0 || cnt !== ((i >= 5) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("[TB] FAIL clean_press edge %0d: got %h expected %h", i, dutVec, modelVec);
      end
    end
    btnIn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dutVec !== modelVec || relP !== (i == 5) || level !== (i < 5) || pressP !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clean_release edge %0d: got %h expected %h", i, dutVec, modelVec);
      end
    end
  endtask

  task automatic test_press_bounce();
    for (int i = 0; i < 13; i++) begin
      btnIn = (i == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (dutVec !== modelVec || pressP !== (i == 9) || level !== (i >= 9)) begin
        errors++;
        $display("[TB] FAIL press_bounce edge %0d: got %h expected %h", i, dutVec, modelVec);
      end
    end
    releaseAndSettle();
  endtask

  task automatic test_long_press();
    int pressEdge = -100;
    int longEdge  = -100;
    int longCount = 0;
    btnIn = 1'b1;
    for (int i = 0; i < 51; i++) begin
      @(negedge clk);
      checks++;
      if (dutVec !== modelVec) begin
        errors++;
        $display("[TB] FAIL long_press edge %0d: got %h expected %h", i, dutVec, modelVec);
      end
      if (pressP === 1'b1) pressEdge = i;
      if (longP === 1'b1) begin
        longCount++;
        longEdge = i;
      end
    end
    checks++;
    if (longCount != 1 || longEdge - pressEdge != L) begin
      errors++;
      $display("[TB] FAIL long_press_timing: got count %0d offset %0d expected 1 and %0d",
               longCount, longEdge - pressEdge, L);
    end
    btnIn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dutVec !== modelVec || relP !== (i == 5) || longP !== 1'b0) begin
        errors++;
        $display("[TB] FAIL long_release edge %0d: got %h expected %h", i, dutVec, modelVec);
      end
    end
  endtask

  task automatic test_release_bounce();
    int longEdge = -100;
    for (int i = 0; i < 41; i++) begin
      btnIn = (i == 10 || i == 11) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (dutVec !== modelVec || relP !== 1'b0 || (i >= 5 && level !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL release_bounce edge %0d: got %h expected %h", i, dutVec, modelVec);
      end
      if (longP === 1'b1) longEdge = i;
    end
    // Press at edge 5; edges 12..14 (leave PRESSED, two RELEASE_WAIT edges) do not advance hold.
    checks++;
    if (longEdge != 5 + L + 3) begin
      errors++;
      $display("[TB] FAIL release_bounce_long: got edge %0d expected %0d", longEdge, 5 + L + 3);
    end
    releaseAndSettle();
  endtask

  task automatic test_reset_mid_press();
    btnIn = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dutVec !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_mid_press: got %h expected 000", dutVec);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dutVec !== modelVec || pressP !== (i == 5) || relP !== 1'b0 ||
          cnt !== ((i >= 5) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("[TB] FAIL repress_after_reset edge %0d: got %h expected %h", i, dutVec, modelVec);
      end
    end
    releaseAndSettle();
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      btnIn = 1'($urandom_range(0, 1));
      len   = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        rst = ($urandom_range(0, 199) == 0);
        @(negedge clk);
        checks++;
        if (dutVec !== modelVec) begin
          errors++;
          $display("[TB] FAIL random seg %0d: got %h expected %h", seg, dutVec, modelVec);
        end
      end
    end
    rst = 1'b0;
    releaseAndSettle();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 256; p++) begin
      btnIn = 1'b1;
      repeat (7) @(negedge clk);
      checks++;
      if (cnt !== 8'(p + 1) || dutVec !== modelVec) begin
        errors++;
        $display("[TB] FAIL wrap press %0d: got count %0d expected %0d", p, cnt, 8'(p + 1));
      end
      btnIn = 1'b0;
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic test_active_low();
    btnInLow = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (lowVec !== modelLowVec || pressLow !== (i == 5) || levelLow !== (i >= 5)) begin
        errors++;
        $display("[TB] FAIL active_low_press edge %0d: got %h expected %h", i, lowVec, modelLowVec);
      end
    end
    btnInLow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (lowVec !== modelLowVec || relLow !== (i == 5) || levelLow !== (i < 5)) begin
        errors++;
        $display("[TB] FAIL active_low_release edge %0d: got %h expected %h", i, lowVec, modelLowVec);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    btnIn    = 1'b0;
    btnInLow = 1'b1;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_long_press();
    test_release_bounce();
    test_reset_mid_press();
    test_random();
    test_wrap();
    test_active_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
